onewire_nvregfile: RTL and testbench

Parametrised successor to the fixed TH/TL/CFG register file of the 1-wire slave. Holds `NREG` EEPROM-backed user bytes, sequences CopyScratchpad (registers → EEPROM) and Recall EEPROM (EEPROM → registers) against an external EEPROM macro, and runs a serial Dallas CRC8 over the register bytes. The adapter consumes the CRC directly, so `conf_dummy` no longer needs to supply `crok`/`reok`. Sits between `onewire_adapter` and the EEPROM macro in the 2.4 MHz domain.

---
 rtl/onewire_nvregfile.sv | 217 +++++++++++++++++++++
 tb/tb_onewire_nvregfile.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onewire_nvregfile.sv
// onewire_nvregfile: NREG EEPROM-backed user bytes (TH, TL, CFG, ...) for the
// 1-wire slave. Sequences CopyScratchpad / Recall EEPROM against an external
// EEPROM macro and keeps a serial Dallas CRC8 of the register bytes up to date.
module onewire_nvregfile #(
   parameter int NREG    = 3,
   parameter int AW      = 4,
   parameter int EE_WAIT = 24000
) (
   input  logic                clk_2m4,
   input  logic                owpo_rst,
   input  logic [NREG-1:0]     owam_reg_we,
   input  logic [7:0]          owam_databus,
   input  logic                owam_copyreg,
   input  logic                owam_recall,
   output logic [8*NREG-1:0]   owam_regs,
   output logic                owam_busy,
   output logic                owam_crok,
   output logic                owam_reok,
   output logic [7:0]          owam_crc,
   output logic                owam_crc_vld,
   output logic [AW-1:0]       ee_addr,
   output logic [7:0]          ee_wdata,
   output logic                ee_we,
   output logic                ee_re,
   input  logic [7:0]          ee_rdata
);

   localparam int NBITS = 8 * NREG;
   localparam int IW    = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int WW    = (EE_WAIT > 1) ? $clog2(EE_WAIT + 1) : 1;
   localparam int CW    = $clog2(NBITS + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CP_WR,
      S_CP_WAIT,
      S_RC_RD,
      S_RC_CAP,
      S_DONE
   } state_t;

   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [WW-1:0]           wait_q, wait_d;
   logic                    copy_q, copy_d;     // operation kind, selects crok vs reok in DONE
   logic [NREG-1:0][7:0]    regs_q, regs_d;
   logic                    cap;                // recall capture of byte idx this cycle
   logic                    chg;                // register contents change at this edge

   // CRC engine state: sh_q is a snapshot of the bytes shifted out LSB first
   logic [NBITS-1:0]        sh_q, sh_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [7:0]              acc_q, acc_d;
   logic [7:0]              crc_q, crc_d;
   logic                    run_q, run_d;
   logic                    vld_q, vld_d;
   logic                    fb;

   // Sequencer state register
   always_ff @(posedge clk_2m4 or posedge owpo_rst) begin
      if (owpo_rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         wait_q  <= '0;
         copy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         copy_q  <= copy_d;
      end
   end

   // Sequencer next state and strobes; requests outside IDLE are dropped
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wait_d    = wait_q;
      copy_d    = copy_q;
      ee_we     = 1'b0;
      ee_re     = 1'b0;
      owam_crok = 1'b0;
      owam_reok = 1'b0;
      cap       = 1'b0;
      case (state_q)
         S_IDLE: begin
            // copy has priority over a simultaneous recall
            if (owam_copyreg) begin
               state_d = S_CP_WR;
               idx_d   = '0;
               copy_d  = 1'b1;
            end else if (owam_recall) begin
               state_d = S_RC_RD;
               idx_d   = '0;
               copy_d  = 1'b0;
            end
         end
         S_CP_WR: begin
            ee_we   = 1'b1;
            wait_d  = '0;
            state_d = S_CP_WAIT;
         end
         S_CP_WAIT: begin
            if (wait_q == WW'(EE_WAIT - 1)) begin
               if (idx_q == IW'(NREG - 1)) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + IW'(1);
                  state_d = S_CP_WR;
               end
            end else begin
               wait_d = wait_q + WW'(1);
            end
         end
         S_RC_RD: begin
            ee_re   = 1'b1;
            state_d = S_RC_CAP;
         end
         S_RC_CAP: begin
            cap = 1'b1;
            if (idx_q == IW'(NREG - 1)) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IW'(1);
               state_d = S_RC_RD;
            end
         end
         S_DONE: begin
            owam_crok = copy_q;
            owam_reok = ~copy_q;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign owam_busy = (state_q != S_IDLE);
   assign ee_addr   = AW'(idx_q);
   assign ee_wdata  = regs_q[idx_q];
   assign owam_regs = regs_q;

   // Register byte next state: recall capture, or adapter writes while idle
   always_comb begin
      regs_d = regs_q;
      chg    = 1'b0;
      if (cap) begin
         regs_d[idx_q] = ee_rdata;
         chg           = 1'b1;
      end else if (state_q == S_IDLE) begin
         for (int k = 0; k < NREG; k++) begin
            if (owam_reg_we[k]) begin
               regs_d[k] = owam_databus;
               chg       = 1'b1;
            end
         end
      end
   end

   // Register byte storage
   always_ff @(posedge clk_2m4 or posedge owpo_rst) begin
      if (owpo_rst) regs_q <= '0;
      else          regs_q <= regs_d;
   end

   assign fb = acc_q[0] ^ sh_q[0];

   // CRC engine: one bit per cycle, restart on any register change, one extra
   // cycle at the end of a pass to publish the result
   always_comb begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      crc_d = crc_q;
      run_d = run_q;
      vld_d = vld_q;
      if (chg) begin
         sh_d  = regs_d;
         cnt_d = '0;
         acc_d = '0;
         run_d = 1'b1;
         vld_d = 1'b0;
      end else if (run_q) begin
         if (cnt_q == CW'(NBITS)) begin
            crc_d = acc_q;
            vld_d = 1'b1;
            run_d = 1'b0;
         end else begin
            acc_d = (acc_q >> 1) ^ (fb ? 8'h8C : 8'h00);
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // CRC engine state; comes out of reset already running over all-zero bytes
   always_ff @(posedge clk_2m4 or posedge owpo_rst) begin
      if (owpo_rst) begin
         sh_q  <= '0;
         cnt_q <= '0;
         acc_q <= '0;
         crc_q <= '0;
         run_q <= 1'b1;
         vld_q <= 1'b0;
      end else begin
         sh_q  <= sh_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         crc_q <= crc_d;
         run_q <= run_d;
         vld_q <= vld_d;
      end
   end

   assign owam_crc     = crc_q;
   assign owam_crc_vld = vld_q;

endmodule

// File: tb/tb_onewire_nvregfile.sv
// Scoreboard bench for onewire_nvregfile: EEPROM strobes and done pulses are
// queued as expectations when a request is driven and checked by a monitor.
module tb_onewire_nvregfile;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // NREG=3 instance with short EEPROM wait
   logic [2:0]  we3 = '0;
   logic [7:0]  db3 = '0;
   logic        cp3 = 1'b0, rc3 = 1'b0;
   logic [23:0] regs3;
   logic        busy3, crok3, reok3, vld3, eewe3, eere3;
   logic [7:0]  crc3, wdata3;
   logic [7:0]  rdata3 = '0;
   logic [3:0]  addr3;

   onewire_nvregfile #(.NREG(3), .AW(4), .EE_WAIT(4)) u3 (
      .clk_2m4(clk), .owpo_rst(rst), .owam_reg_we(we3), .owam_databus(db3),
      .owam_copyreg(cp3), .owam_recall(rc3), .owam_regs(regs3), .owam_busy(busy3),
      .owam_crok(crok3), .owam_reok(reok3), .owam_crc(crc3), .owam_crc_vld(vld3),
      .ee_addr(addr3), .ee_wdata(wdata3), .ee_we(eewe3), .ee_re(eere3), .ee_rdata(rdata3));

   // NREG=7 instance for the known CRC vector
   logic [6:0]  we7 = '0;
   logic [7:0]  db7 = '0;
   logic        cp7 = 1'b0, rc7 = 1'b0;
   logic [55:0] regs7;
   logic        busy7, crok7, reok7, vld7, eewe7, eere7;
   logic [7:0]  crc7, wdata7;
   logic [7:0]  rdata7 = '0;
   logic [3:0]  addr7;

   onewire_nvregfile #(.NREG(7), .AW(4), .EE_WAIT(4)) u7 (
      .clk_2m4(clk), .owpo_rst(rst), .owam_reg_we(we7), .owam_databus(db7),
      .owam_copyreg(cp7), .owam_recall(rc7), .owam_regs(regs7), .owam_busy(busy7),
      .owam_crok(crok7), .owam_reok(reok7), .owam_crc(crc7), .owam_crc_vld(vld7),
      .ee_addr(addr7), .ee_wdata(wdata7), .ee_we(eewe7), .ee_re(eere7), .ee_rdata(rdata7));

   // EEPROM model: write on strobe, read data registered for the next cycle
   logic [7:0] mem [16];
   initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
   always @(posedge clk) begin
      if (eewe3) mem[addr3] <= wdata3;
      if (eere3) rdata3 <= mem[addr3];
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] crc8(input logic [55:0] v, input int nbytes);
      logic [7:0] c;
      logic       f;
      c = 8'h00;
      for (int i = 0; i < nbytes * 8; i++) begin
         f = c[0] ^ v[i];
         c = c >> 1;
         if (f) c = c ^ 8'h8C;
      end
      return c;
   endfunction

   typedef struct {
      logic       is_wr;
      logic [3:0] addr;
      logic [7:0] data;
      int         rel;
   } ee_exp_t;

   ee_exp_t ee_q[$];
   int      crok_q[$];
   int      reok_q[$];
   int      base = 0;

   // Monitor: every strobe / pulse must match the next queued expectation
   always @(negedge clk) begin
      ee_exp_t e;
      int      r;
      if (eewe3 || eere3) begin
         if (ee_q.size() == 0) chk("ee_unexpected", 1, 0);
         else begin
            e = ee_q.pop_front();
            chk("ee_kind", eewe3, e.is_wr);
            chk("ee_addr", addr3, e.addr);
            if (e.is_wr) chk("ee_wdata", wdata3, e.data);
            chk("ee_cycle", cyc - base, e.rel);
         end
      end
      if (crok3) begin
         if (crok_q.size() == 0) chk("crok_unexpected", 1, 0);
         else begin r = crok_q.pop_front(); chk("crok_cycle", cyc - base, r); end
      end
      if (reok3) begin
         if (reok_q.size() == 0) chk("reok_unexpected", 1, 0);
         else begin r = reok_q.pop_front(); chk("reok_cycle", cyc - base, r); end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr3(input int k, input logic [7:0] v);
      we3 = 3'(1 << k);
      db3 = v;
      @(negedge clk);
      we3 = '0;
      chk("wr_visible", regs3[8*k +: 8], v);
      chk("wr_clears_vld", vld3, 0);
   endtask

   // Drive a one-cycle request; returns at the negedge of cycle 1
   task automatic start_op(input logic c, input logic r);
      cp3  = c;
      rc3  = r;
      base = cyc;
      @(negedge clk);
      cp3 = 1'b0;
      rc3 = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy3 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("idle_wait", busy3, 0);
   endtask

   task automatic push_wr(input logic [3:0] a, input logic [7:0] d, input int rel);
      ee_exp_t e;
      e.is_wr = 1'b1; e.addr = a; e.data = d; e.rel = rel;
      ee_q.push_back(e);
   endtask

   task automatic push_rd(input logic [3:0] a, input int rel);
      ee_exp_t e;
      e.is_wr = 1'b0; e.addr = a; e.data = 8'h00; e.rel = rel;
      ee_q.push_back(e);
   endtask

   initial begin
      logic [55:0] vec;
      logic [23:0] b3;
      int          rr;

      // Reset values and CRC of zeros
      tick(3);
      chk("rst_regs", regs3, 0);
      chk("rst_crc", crc3, 0);
      chk("rst_vld", vld3, 0);
      chk("rst_busy", busy3, 0);
      chk("rst_crok", crok3, 0);
      chk("rst_reok", reok3, 0);
      chk("rst_ee_we", eewe3, 0);
      chk("rst_ee_re", eere3, 0);
      chk("rst_ee_addr", addr3, 0);
      chk("rst_ee_wdata", wdata3, 0);
      rst = 1'b0;
      tick(24);
      chk("crc0_vld_c24", vld3, 0);
      tick(1);
      chk("crc0_vld_c25", vld3, 1);
      chk("crc0_val", crc3, 8'h00);

      // Known CRC vector on the NREG=7 instance
      vec = 56'h00_0000_01B8_1C02;
      for (int i = 0; i < 7; i++) begin
         we7 = 7'(1 << i);
         db7 = vec[8*i +: 8];
         @(negedge clk);
      end
      we7 = '0;
      chk("vec_regs", regs7[31:0], vec[31:0]);
      tick(56);
      chk("vec_vld_early", vld7, 0);
      tick(1);
      chk("vec_vld", vld7, 1);
      chk("vec_crc_const", crc7, 8'hA2);
      chk("vec_crc_model", crc7, crc8(vec, 7));

      // Copy of 4B 46 7F
      wr3(0, 8'h4B);
      wr3(1, 8'h46);
      wr3(2, 8'h7F);
      b3 = 24'h7F464B;
      tick(26);
      chk("crc3_vld", vld3, 1);
      chk("crc3_val", crc3, crc8({32'h0, b3}, 3));
      push_wr(4'd0, 8'h4B, 1);
      push_wr(4'd1, 8'h46, 6);
      push_wr(4'd2, 8'h7F, 11);
      crok_q.push_back(16);
      start_op(1'b1, 1'b0);
      for (int r = 1; r <= 17; r++) begin
         chk($sformatf("copy_busy_c%0d", r), busy3, (r <= 16) ? 1 : 0);
         @(negedge clk);
      end
      wait_idle(10);
      chk("copy_q_empty", ee_q.size(), 0);
      chk("copy_crok_seen", crok_q.size(), 0);
      chk("copy_mem0", mem[0], 8'h4B);
      chk("copy_mem1", mem[1], 8'h46);
      chk("copy_mem2", mem[2], 8'h7F);

      // Recall of 11 22 33 with a write attempted at cycle 3
      mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
      push_rd(4'd0, 1);
      push_rd(4'd1, 3);
      push_rd(4'd2, 5);
      reok_q.push_back(7);
      start_op(1'b0, 1'b1);
      tick(2);
      we3 = 3'b001;
      db3 = 8'hEE;
      @(negedge clk);
      we3 = '0;
      wait_idle(20);
      tick(2);
      chk("rc_regs", regs3, 24'h332211);
      chk("rc_q_empty", ee_q.size(), 0);
      chk("rc_reok_seen", reok_q.size(), 0);
      tick(26);
      chk("rc_crc_vld", vld3, 1);
      chk("rc_crc_val", crc3, crc8({32'h0, 24'h332211}, 3));

      // Simultaneous copy+recall, then a second copy mid-copy
      push_wr(4'd0, 8'h11, 1);
      push_wr(4'd1, 8'h22, 6);
      push_wr(4'd2, 8'h33, 11);
      crok_q.push_back(16);
      start_op(1'b1, 1'b1);
      tick(4);
      cp3 = 1'b1;
      @(negedge clk);
      cp3 = 1'b0;
      wait_idle(40);
      tick(25);
      chk("sim_q_empty", ee_q.size(), 0);
      chk("sim_crok_seen", crok_q.size(), 0);

      // Reset during CP_WAIT of word 1
      wr3(0, 8'hA1);
      wr3(1, 8'hB2);
      wr3(2, 8'hC3);
      push_wr(4'd0, 8'hA1, 1);
      push_wr(4'd1, 8'hB2, 6);
      start_op(1'b1, 1'b0);
      tick(7);
      rst = 1'b1;
      #1;
      chk("mid_ee_we", eewe3, 0);
      chk("mid_busy", busy3, 0);
      chk("mid_regs", regs3, 0);
      chk("mid_crok", crok3, 0);
      chk("mid_q_empty", ee_q.size(), 0);
      tick(3);
      rst = 1'b0;
      tick(30);
      chk("mid_mem0", mem[0], 8'hA1);
      chk("mid_mem1", mem[1], 8'hB2);
      chk("mid_mem2", mem[2], 8'h33);
      chk("mid_idle", busy3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
